fence_seq: RTL and testbench
============================

Name: fence_seq

Overview:
- Sequences the multi-step cache/TLB maintenance behind FENCE, FENCE.I and SFENCE.VMA after commit hands off the instruction.
- Sits between commit and the flush controller's resource outputs.
- Stalls commit via halt_o, drains the store buffer, then walks the D$ flush handshake, I$ flush, TLB flush and pipeline flush in a fixed order.
- Emits one done pulse per request.

Parameters:
- WT_DCACHE, 1, 1 = write-through D$: the D$ flush step is skipped; 0 = write-back, full flush handshake required.
- TIMEOUT_CYCLES, 1024, watchdog limit on the D$ ack wait (used only with the optional feature). Must be ≥ 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  1  maintenance request from commit.
- req_op_i  in  2  0=FENCE, 1=FENCE_I, 2=SFENCE_VMA, 3=reserved.
- req_ready_o  out  1  high only in IDLE.
- stbuf_empty_i  in  1  store buffer fully drained.
- flush_dcache_o  out  1  level request to D$.
- flush_dcache_ack_i  in  1  D$ flush complete, one-cycle pulse.
- flush_icache_o  out  1  one-cycle I$ invalidate.
- flush_tlb_o  out  1  one-cycle TLB flush.
- flush_pipe_o  out  1  one-cycle IF/ID/EX/unissued flush.
- set_pc_o  out  1  one-cycle redirect to PC+4; coincident with flush_pipe_o.
- halt_o  out  1  stall commit; high in every state except IDLE.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  watchdog fired on the last request.

Behaviour:
- Reset (rst_i high at a clock edge):
  - State goes to IDLE. Counter cleared. err_o cleared.
  - All outputs 0, except req_ready_o=1.
  - Reset overrides everything, including mid-sequence and a simultaneous request. An in-flight D$ flush is abandoned; the D$ is reset by the same rst_i.
- Output timing: all outputs are decoded from the registered state only. There is no combinational input-to-output path.
- Accept: on req_valid_i & req_ready_o at an edge, latch req_op_i, clear err_o, and go to DRAIN. Requests outside IDLE are ignored (req_ready_o=0).
- States and transitions:
  - IDLE: waits for an accepted request.
  - DRAIN: leave when stbuf_empty_i=1.
    - FENCE or FENCE_I → DCACHE if WT_DCACHE=0, else FENCE → PIPE and FENCE_I → ICACHE.
    - SFENCE_VMA → TLB.
    - Reserved op → DONE directly; no flush outputs asserted.
  - DCACHE: flush_dcache_o=1. On flush_dcache_ack_i=1: FENCE → PIPE, FENCE_I → ICACHE. flush_dcache_o drops in the cycle after the ack.
  - ICACHE: flush_icache_o=1 for exactly one cycle → PIPE.
  - TLB: flush_tlb_o=1 for exactly one cycle → PIPE.
  - PIPE: flush_pipe_o=1 and set_pc_o=1 for one cycle → DONE.
  - DONE: done_o=1 for one cycle → IDLE.
- flush_dcache_ack_i is sampled only in DCACHE. A stray ack in any other state is ignored.
- stbuf_empty_i is sampled only in DRAIN.
- Minimum latency, accept edge to done_o, counted in cycles in non-IDLE states:
  - FENCE_I, WT_DCACHE=1, buffer empty: 4 cycles (DRAIN, ICACHE, PIPE, DONE).
  - WT_DCACHE=0 with ack one cycle after DCACHE entry: 6 cycles.
- Back-to-back requests: a new request can be accepted on the edge after DONE, i.e. IDLE lasts at least one cycle.

Optional Feature:
- Macro: FENCE_SEQ_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES)+1 clears on DCACHE entry and increments each DCACHE cycle without ack.
  - When the count reaches TIMEOUT_CYCLES-1 with no ack, the next state is PIPE (skipping ICACHE) and err_o is set.
  - err_o is sticky until the next accept or reset.
  - An ack in the same cycle as the limit wins: normal path, err_o stays 0.
- Undefined: no counter; DCACHE waits indefinitely; err_o is tied to 0.

Decomposition:
- Package fence_seq_pkg holds:
  - fence_op_e, a 2-bit enum: FENCE, FENCE_I, SFENCE_VMA, RSVD.
  - fence_state_e: IDLE, DRAIN, DCACHE, ICACHE, TLB, PIPE, DONE.
  - Op encoding constants shared with commit.
- One natural sub-module, fence_seq_wdog: clear/enable/limit counter with an expired output. It is instantiated only under FENCE_SEQ_TIMEOUT_EN.
- The FSM stays in fence_seq.

Test Plan:
- FENCE_I, WT_DCACHE=1, stbuf_empty_i=1 → flush_icache_o, then flush_pipe_o+set_pc_o, then done_o on consecutive cycles; done_o 4 cycles after accept; halt_o high for those 4 cycles.
- FENCE, WT_DCACHE=0, stbuf_empty_i held 0 for 5 cycles, ack 3 cycles after DCACHE entry → flush_dcache_o high exactly 4 cycles; no flush_icache_o or flush_tlb_o; done_o once.
- SFENCE_VMA, plus a stray flush_dcache_ack_i pulse during DRAIN → ack ignored; flush_tlb_o one cycle, then flush_pipe_o; flush_dcache_o never asserted.
- req_valid_i held high across completion, then op=3 → second request accepted one cycle after DONE; reserved op gives done_o 2 cycles after accept with no flush outputs.
- rst_i asserted in DCACHE with a simultaneous req_valid_i → next cycle IDLE, all outputs 0, req_ready_o=1, request dropped.
- FENCE_SEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, no ack → after 8 DCACHE cycles goes to PIPE, err_o=1, no flush_icache_o; next accept clears err_o.

Source files
------------

// File: rtl/fence_seq_pkg.sv
// Shared types for the fence/maintenance sequencer: request op encoding and FSM states.
package fence_seq_pkg;

  // Op encoding as driven by commit on req_op_i
  localparam logic [1:0] OPC_FENCE      = 2'd0;
  localparam logic [1:0] OPC_FENCE_I    = 2'd1;
  localparam logic [1:0] OPC_SFENCE_VMA = 2'd2;
  localparam logic [1:0] OPC_RSVD       = 2'd3;

  typedef enum logic [1:0] {
    FENCE      = OPC_FENCE,
    FENCE_I    = OPC_FENCE_I,
    SFENCE_VMA = OPC_SFENCE_VMA,
    RSVD       = OPC_RSVD
  } fence_op_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    DCACHE = 3'd2,
    ICACHE = 3'd3,
    TLB    = 3'd4,
    PIPE   = 3'd5,
    DONE   = 3'd6
  } fence_state_e;

endpackage

// File: rtl/fence_seq_wdog.sv
// Watchdog counter for the D$ ack wait: clear, count while enabled, flag the limit.
module fence_seq_wdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = $clog2(LIMIT) + 1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/fence_seq.sv
// Sequencer for FENCE / FENCE.I / SFENCE.VMA maintenance steps after commit.
// Optional D$ ack watchdog enabled by defining FENCE_SEQ_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | ready for a request from commit
// DRAIN  | commit halted, waiting for the store buffer to empty
// DCACHE | D$ flush requested, waiting for ack
// ICACHE | one-cycle I$ invalidate
// TLB    | one-cycle TLB flush
// PIPE   | one-cycle pipeline flush + redirect to PC+4
// DONE   | one-cycle completion pulse
module fence_seq
  import fence_seq_pkg::*;
#(
  parameter int WT_DCACHE      = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  input  logic [1:0] req_op_i,
  output logic       req_ready_o,
  input  logic       stbuf_empty_i,
  output logic       flush_dcache_o,
  input  logic       flush_dcache_ack_i,
  output logic       flush_icache_o,
  output logic       flush_tlb_o,
  output logic       flush_pipe_o,
  output logic       set_pc_o,
  output logic       halt_o,
  output logic       done_o,
  output logic       err_o
);

  localparam bit WT = (WT_DCACHE != 0);

  fence_state_e state_q, state_d;
  fence_op_e    op_q, op_d;
  logic         err_q, err_d;
  logic         wdog_expired;

`ifdef FENCE_SEQ_TIMEOUT_EN
  fence_seq_wdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    ((state_d == DCACHE) && (state_q != DCACHE)),
    .en_i     ((state_q == DCACHE) && !flush_dcache_ack_i),
    .expired_o(wdog_expired)
  );
`else
  assign wdog_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          op_d    = fence_op_e'(req_op_i);
          err_d   = 1'b0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (stbuf_empty_i) begin
          case (op_q)
            FENCE:      state_d = WT ? PIPE : DCACHE;
            FENCE_I:    state_d = WT ? ICACHE : DCACHE;
            SFENCE_VMA: state_d = TLB;
            default:    state_d = DONE;
          endcase
        end
      end
      DCACHE: begin
        // An ack coinciding with the watchdog limit takes the normal path
        if (flush_dcache_ack_i) begin
          state_d = (op_q == FENCE_I) ? ICACHE : PIPE;
        end else if (wdog_expired) begin
          state_d = PIPE;
          err_d   = 1'b1;
        end
      end
      ICACHE:  state_d = PIPE;
      TLB:     state_d = PIPE;
      PIPE:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= FENCE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o    = (state_q == IDLE);
  assign halt_o         = (state_q != IDLE);
  assign flush_dcache_o = (state_q == DCACHE);
  assign flush_icache_o = (state_q == ICACHE);
  assign flush_tlb_o    = (state_q == TLB);
  assign flush_pipe_o   = (state_q == PIPE);
  assign set_pc_o       = (state_q == PIPE);
  assign done_o         = (state_q == DONE);
  assign err_o          = err_q;

endmodule

// File: tb/tb_fence_seq.sv
// Bench for fence_seq: a write-through instance [0] and a write-back instance [1],
// checked cycle by cycle against an expected trace derived from the op/latency rules.
module tb_fence_seq;

  localparam int T = 8;

  logic       clk;
  logic       rst;
  logic       req_valid [2];
  logic [1:0] req_op    [2];
  logic       req_ready [2];
  logic       stbuf     [2];
  logic       fd        [2];
  logic       ack       [2];
  logic       fi        [2];
  logic       ft        [2];
  logic       fp        [2];
  logic       spc       [2];
  logic       halt      [2];
  logic       done      [2];
  logic       err       [2];

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] exp_q[$];

  fence_seq #(.WT_DCACHE(1), .TIMEOUT_CYCLES(T)) dut_wt (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[0]), .req_op_i(req_op[0]), .req_ready_o(req_ready[0]),
    .stbuf_empty_i(stbuf[0]), .flush_dcache_o(fd[0]), .flush_dcache_ack_i(ack[0]),
    .flush_icache_o(fi[0]), .flush_tlb_o(ft[0]), .flush_pipe_o(fp[0]),
    .set_pc_o(spc[0]), .halt_o(halt[0]), .done_o(done[0]), .err_o(err[0])
  );

  fence_seq #(.WT_DCACHE(0), .TIMEOUT_CYCLES(T)) dut_wb (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[1]), .req_op_i(req_op[1]), .req_ready_o(req_ready[1]),
    .stbuf_empty_i(stbuf[1]), .flush_dcache_o(fd[1]), .flush_dcache_ack_i(ack[1]),
    .flush_icache_o(fi[1]), .flush_tlb_o(ft[1]), .flush_pipe_o(fp[1]),
    .set_pc_o(spc[1]), .halt_o(halt[1]), .done_o(done[1]), .err_o(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ready, halt, dcache, icache, tlb, pipe, set_pc, done, err}
  function automatic logic [8:0] obs(input int i);
    return {req_ready[i], halt[i], fd[i], fi[i], ft[i], fp[i], spc[i], done[i], err[i]};
  endfunction

  function automatic logic [8:0] v(input bit d_, input bit i_, input bit t_,
                                   input bit p_, input bit dn, input bit er);
    return {1'b0, 1'b1, d_, i_, t_, p_, p_, dn, er};
  endfunction

  // Expected per-cycle outputs from the accept edge to the done pulse
  task automatic build_exp(input int inst, input int op, input int d, input int k);
    bit er = 1'b0;
    bit skip_i = 1'b0;
    exp_q.delete();
    repeat (d + 1) exp_q.push_back(v(0, 0, 0, 0, 0, 0));
    if (op == 3) begin
      exp_q.push_back(v(0, 0, 0, 0, 1, 0));
      return;
    end
    if (op <= 1 && inst == 1) begin
`ifdef FENCE_SEQ_TIMEOUT_EN
      if (k >= T) begin
        repeat (T) exp_q.push_back(v(1, 0, 0, 0, 0, 0));
        er = 1'b1;
        skip_i = 1'b1;
      end else
`endif
        repeat (k + 1) exp_q.push_back(v(1, 0, 0, 0, 0, 0));
    end
    if (op == 1 && !skip_i) exp_q.push_back(v(0, 1, 0, 0, 0, 0));
    if (op == 2) exp_q.push_back(v(0, 0, 1, 0, 0, 0));
    exp_q.push_back(v(0, 0, 0, 1, 0, er));
    exp_q.push_back(v(0, 0, 0, 0, 1, er));
  endtask

  task automatic run_req(input int inst, input int op, input int d, input int k,
                         input bit stray, input bit hold);
    logic [8:0] got;
    int ack_cyc;
    build_exp(inst, op, d, k);
    ack_cyc = (op <= 1 && inst == 1) ? d + 1 + k : -1;
    @(negedge clk);
    got = obs(inst);
    n_checks++;
    if (got[8:7] !== 2'b10) begin
      n_errors++;
      $display("FAIL idle_before_req inst%0d: ready/halt got %b expected 10", inst, got[8:7]);
    end
    req_valid[inst] = 1'b1;
    req_op[inst]    = op[1:0];
    @(posedge clk); #1;
    req_valid[inst] = hold;
    if (hold) req_op[inst] = 2'd3;
    for (int c = 0; c < exp_q.size(); c++) begin
      stbuf[inst] = (c >= d);
      ack[inst]   = (c == ack_cyc) || (stray && c == 0);
      @(negedge clk);
      got = obs(inst);
      n_checks++;
      if (got !== exp_q[c]) begin
        n_errors++;
        $display("FAIL trace inst%0d op%0d d%0d k%0d cyc%0d: got %b expected %b",
                 inst, op, d, k, c, got, exp_q[c]);
      end
      @(posedge clk); #1;
    end
    ack[inst]   = 1'b0;
    stbuf[inst] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_op[i] = 2'd0; stbuf[i] = 1'b0; ack[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (obs(i) !== 9'b100000000) begin
        n_errors++;
        $display("FAIL reset_state inst%0d: got %b expected 100000000", i, obs(i));
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_fence_i_wt();
    run_req(0, 1, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_fence_wb_drain();
    run_req(1, 0, 5, 3, 1'b0, 1'b0);
  endtask

  task automatic test_sfence_stray();
    run_req(1, 2, 2, 0, 1'b1, 1'b0);
    run_req(0, 2, 1, 0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_req(0, 0, 0, 0, 1'b0, 1'b1);
    run_req(0, 3, 0, 0, 1'b0, 1'b0);
    run_req(1, 1, 0, 0, 1'b0, 1'b1);
    run_req(1, 3, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid[1] = 1'b1; req_op[1] = 2'd0;
    @(posedge clk); #1;
    req_valid[1] = 1'b0; stbuf[1] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (fd[1] !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_mid_in_dcache: flush_dcache got %b expected 1", fd[1]);
    end
    rst = 1'b1; req_valid[1] = 1'b1; req_op[1] = 2'd1;
    @(posedge clk); #1;
    rst = 1'b0; req_valid[1] = 1'b0; stbuf[1] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs(1) !== 9'b100000000) begin
      n_errors++;
      $display("FAIL reset_mid_idle: got %b expected 100000000", obs(1));
    end
    @(negedge clk);
    n_checks++;
    if (obs(1) !== 9'b100000000) begin
      n_errors++;
      $display("FAIL reset_mid_dropped: got %b expected 100000000", obs(1));
    end
  endtask

`ifdef FENCE_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    run_req(1, 1, 1, 99, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (err[1] !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout_err_sticky: got %b expected 1", err[1]);
    end
    run_req(1, 0, 0, 1, 1'b0, 1'b0);
    run_req(1, 1, 0, T - 1, 1'b0, 1'b0);
  endtask
`endif

  task automatic test_random();
    int inst, op, d, k;
    bit stray;
    for (int n = 0; n < 40; n++) begin
      inst  = $urandom_range(0, 1);
      op    = $urandom_range(0, 3);
      d     = $urandom_range(0, 4);
`ifdef FENCE_SEQ_TIMEOUT_EN
      k     = $urandom_range(0, 10);
`else
      k     = $urandom_range(0, 5);
`endif
      stray = 1'($urandom_range(0, 1));
      run_req(inst, op, d, k, stray, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_fence_i_wt();
    test_fence_wb_drain();
    test_sfence_stray();
    test_back_to_back();
    test_reset_mid();
`ifdef FENCE_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
